// File: rtl/uart_rx_block_if.sv
// Block handshake bundle between the UART block receiver and its consumer.
// master drives block_out/block_valid; slave drives block_ready.
interface uart_rx_block_if;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready;

    modport master (
        output block_out,
        output block_valid,
        input  block_ready
    );

    modport slave (
        input  block_out,
        input  block_valid,
        output block_ready
    );
endinterface

// File: rtl/uart_rx_block.sv
// 8N1 UART receiver that packs 16 bytes into a 128-bit block (byte 0 in [7:0]).
// Ports: clock, reset (async high), Rx_in serial line, blk (master: block_out,
// block_valid, block_ready), byte_count, frame_error pulse, sticky overrun.
module uart_rx_block #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Rx_in,
    uart_rx_block_if.master   blk,
    output logic [3:0]        byte_count,
    output logic              frame_error,
    output logic              overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t          state;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;

    logic [119:0]    asm_reg;

    logic            stop_hit;
    logic            byte_done;
    logic            blk_done;
    logic            slot_free;
    logic            load;

    // Synchroniser resets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= Rx_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Stop-bit sample is decoded combinationally so the assembler acts on the
    // same edge; the block is then visible on the very next output edge.
    assign stop_hit  = (state == STOP) && (clk_cnt == BIT_LAST);
    assign byte_done = stop_hit && rx_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_hit) begin
                        clk_cnt     <= '0;
                        frame_error <= !rx_s;
                        state       <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        blk_done  = byte_done && (byte_count == 4'd15);
        slot_free = !blk.block_valid || blk.block_ready;
        load      = blk_done && slot_free;
    end

    // byte_count wraps 15 -> 0 by natural 4-bit overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            asm_reg         <= '0;
            byte_count      <= '0;
            blk.block_out   <= '0;
            blk.block_valid <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            if (byte_done) begin
                for (int i = 0; i < 15; i++) begin
                    if (byte_count == 4'(i)) begin
                        asm_reg[8*i +: 8] <= shift_reg;
                    end
                end
                byte_count <= byte_count + 4'd1;
            end

            if (load) begin
                blk.block_out   <= {shift_reg, asm_reg};
                blk.block_valid <= 1'b1;
            end else if (blk.block_valid && blk.block_ready) begin
                blk.block_valid <= 1'b0;
            end

            if (blk_done && !slot_free) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_rx_block.md
Name: uart_rx_block

Overview:
- Receive-side counterpart of the transmitter's serial output stage.
- Deserialises an 8N1 UART stream (LSB first) and reassembles 16 consecutive bytes into one 128-bit block.
- Presents the block to the downstream deinterleaver/decoder with a valid/ready handshake.
- Byte 0 received lands in block_out[7:0]; byte 15 lands in block_out[127:120]. This matches the transmitter, which shifts its 128-bit buffer right by 8 bits after each byte.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be at least 4.
- SYNC_STAGES, 2: number of flops in the rx input synchroniser.

Ports:
- clock, input, 1: system clock. All logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- Rx_in, input, 1: serial line. Idles high.
- block_ready, input, 1: consumer accepts block_out when block_valid && block_ready.
- block_out, output, 128: assembled block.
- block_valid, output, 1: block_out holds an unconsumed block.
- byte_count, output, 4: number of bytes collected toward the current block (0..15).
- frame_error, output, 1: one-cycle pulse when a stop bit is sampled low.
- overrun, output, 1: sticky flag. Set when a completed block is dropped. Cleared only by reset.

Behaviour:
- Reset (async, any time, including mid-frame or mid-block):
  - Outputs: block_out=0, block_valid=0, byte_count=0, frame_error=0, overrun=0.
  - Internal: FSM=IDLE, bit/clock counters=0, shift register=0.
  - Synchroniser flops reset to 1 (line idle).
  - Any partially received byte or block is discarded.
- Synchroniser: Rx_in passes through SYNC_STAGES flops. Only the synchronised signal rx_s is used below.
- Receive FSM:
  - IDLE: when rx_s==0, go to START with clk_cnt=0.
  - START: count to CLKS_PER_BIT/2-1 (integer division) to reach mid-start-bit, then sample.
    - rx_s==0: go to DATA with clk_cnt=0, bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no other effect.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s mid-bit and shift it into shift_reg[7] (right shift, LSB first).
    - After the 8th sample (bit_idx==7), go to STOP with clk_cnt=0.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s==1: assert byte_done for one cycle.
    - rx_s==0: pulse frame_error for one cycle; the byte is discarded and byte_count is unchanged.
    - Either way, return to IDLE in the next cycle. A start bit immediately following the stop bit is detected without loss.
- Assembler:
  - On byte_done, write the byte to asm_reg[8*byte_count +: 8] and increment byte_count.
  - On byte_done with byte_count==15:
    - byte_count wraps to 0.
    - Output slot free (block_valid==0, or block_ready==1 in the same cycle): block_out <= {byte, asm_reg[119:0]} and block_valid <= 1 in the following cycle.
    - Output slot occupied and not being consumed: the new block is dropped, overrun <= 1, and block_out/block_valid are unchanged.
- Handshake:
  - block_valid stays high and block_out stays stable until a cycle with block_ready==1.
  - Acceptance with no simultaneous load: block_valid <= 0 next cycle.
  - Acceptance and load in the same cycle: block_valid stays 1 and block_out takes the new block. Neither is dropped.
  - block_ready has no effect while block_valid==0.
- Latency:
  - The first output edge after the stop-bit sample of byte 15 shows block_valid=1.
  - The stop-bit sample occurs SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (±1) cycles after the falling edge of that byte's start bit on Rx_in.
- The block does not resynchronise on inter-byte gaps. Idle time of any length between bytes is allowed and does not reset byte_count.

Test Plan:
- Reset then 16 clean frames (CLKS_PER_BIT=16) with bytes 0x00..0x0F, block_ready=1 → exactly one block_valid pulse, block_out=128'h0F0E0D0C0B0A09080706050403020100, byte_count returns to 0, frame_error=overrun=0.
- Single byte 0xA5 with stop bit forced low → one frame_error pulse, byte_count stays 0; then 16 clean bytes of 0xFF → block_out=all ones.
- Low glitch of 3 cycles on idle line → FSM returns to IDLE, no byte counted, no error.
- block_ready=0, send 32 bytes (0x11 ×16 then 0x22 ×16) → block_out holds all-0x11 with valid high, overrun=1 after byte 32; raise block_ready → valid drops next cycle.
- block_ready asserted exactly in the cycle the second block completes → block_out updates to the second block, valid stays 1, overrun stays 0.
- Assert reset mid-byte after 7 bytes received → all outputs 0 immediately (asynchronously); next 16 bytes form a correct block starting at byte 0.
